// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the fetch/data SRAM arbiter.
//   state_e : arbiter FSM states (IDLE, ACCESS, DONE)
//   owner_e : which requester owns the access in flight (fetch or data)
//   RAM_AW  : SRAM word-address width
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   localparam int RAM_AW = 20;

endpackage

// File: rtl/mem_arbiter_arb_priority.sv
// arb_priority: combinational grant selection between the fetch and data ports.
//   d_req_i      : data port request
//   if_req_i     : fetch port request
//   starve_hit_i : fetch has waited the allowed number of data grants
//   grant_o      : some requester is granted this cycle
//   owner_o      : granted owner (OWN_D / OWN_IF encoding from the package)
module arb_priority
   import mem_arbiter_pkg::*;
(
   input  logic d_req_i,
   input  logic if_req_i,
   input  logic starve_hit_i,
   output logic grant_o,
   output logic owner_o
);

   assign grant_o = d_req_i | if_req_i;

   // Data normally wins; a starved fetch only overrides when it is actually requesting.
   assign owner_o = (d_req_i && !(if_req_i && starve_hit_i)) ? OWN_D : OWN_IF;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port asynchronous SRAM between the fetch port
// and the data (load/store) port. Each access runs IDLE -> ACCESS (WAIT_CYCLES
// strobe cycles) -> DONE (one-cycle ack, write hold) -> IDLE.
//   clk, rst                    : clock, asynchronous active-low reset
//   if_req/if_addr              : fetch request in; if_rdata/if_ack out
//   d_req/d_we/d_be/d_addr/d_wdata : data request in; d_rdata/d_ack out
//   ram_addr/ram_wdata/ram_rdata   : SRAM word address, write and read data
//   ram_ce_n/ram_oe_n/ram_we_n/ram_be_n : SRAM strobes, active-low
//   busy                        : access in progress (ACCESS or DONE)
// Optional: define ARB_STARVE_GUARD_EN to let a waiting fetch win after
// STARVE_MAX consecutive data grants; otherwise data has strict priority.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int STARVE_MAX  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [31:0]         if_addr,
   output logic [31:0]         if_rdata,
   output logic                if_ack,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [3:0]          d_be,
   input  logic [31:0]         d_addr,
   input  logic [31:0]         d_wdata,
   output logic [31:0]         d_rdata,
   output logic                d_ack,
   output logic [RAM_AW-1:0]   ram_addr,
   output logic [31:0]         ram_wdata,
   input  logic [31:0]         ram_rdata,
   output logic                ram_ce_n,
   output logic                ram_oe_n,
   output logic                ram_we_n,
   output logic [3:0]          ram_be_n,
   output logic                busy
);

   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 7 || STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_param
      $error("mem_arbiter: WAIT_CYCLES and STARVE_MAX must be in 1..7");
   end

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [RAM_AW-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [3:0]          be_q, be_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         if_rdata_q, if_rdata_d;
   logic [31:0]         d_rdata_q, d_rdata_d;
   logic                grant, gnt_own, starve_hit, last;
   logic                unused;

   // Byte offset and bits above the SRAM window are not used for addressing.
   assign unused = ^{if_addr[31:RAM_AW+2], if_addr[1:0], d_addr[31:RAM_AW+2], d_addr[1:0]};

   arb_priority u_prio (
      .d_req_i      (d_req),
      .if_req_i     (if_req),
      .starve_hit_i (starve_hit),
      .grant_o      (grant),
      .owner_o      (gnt_own)
   );

`ifdef ARB_STARVE_GUARD_EN
   logic [2:0] starve_q, starve_d;
   assign starve_hit = starve_q == 3'(STARVE_MAX);
   // Counts data grants that made a requesting fetch wait; a fetch grant clears it.
   always_comb begin
      starve_d = starve_q;
      if (state_q == IDLE && grant)
         starve_d = (gnt_own == OWN_IF) ? 3'd0 : starve_q + 3'(if_req);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) starve_q <= 3'd0;
      else      starve_q <= starve_d;
   end
`else
   assign starve_hit = 1'b0;
`endif

   assign last = cnt_q == 3'(WAIT_CYCLES - 1);

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      we_d       = we_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (grant) begin
               state_d = ACCESS;
               cnt_d   = 3'd0;
               owner_d = owner_e'(gnt_own);
               addr_d  = (gnt_own == OWN_D) ? d_addr[RAM_AW+1:2] : if_addr[RAM_AW+1:2];
               we_d    = (gnt_own == OWN_D) && d_we;
               be_d    = ((gnt_own == OWN_D) && d_we) ? d_be : 4'hF;
               wdata_d = (gnt_own == OWN_D) ? d_wdata : 32'h0;
            end
         end
         ACCESS: begin
            cnt_d = cnt_q + 3'd1;
            if (last) begin
               state_d = DONE;
               if (!we_q && owner_q == OWN_D)  d_rdata_d  = ram_rdata;
               if (!we_q && owner_q == OWN_IF) if_rdata_d = ram_rdata;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         owner_q    <= OWN_IF;
         cnt_q      <= 3'd0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         be_q       <= 4'h0;
         wdata_q    <= 32'h0;
         if_rdata_q <= 32'h0;
         d_rdata_q  <= 32'h0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   // DONE keeps chip enable and address/data asserted with both OE and WE released,
   // giving the SRAM its write hold time.
   assign busy      = state_q != IDLE;
   assign ram_ce_n  = !busy;
   assign ram_oe_n  = !(state_q == ACCESS && !we_q);
   assign ram_we_n  = !(state_q == ACCESS && we_q);
   assign ram_be_n  = busy ? ~be_q : 4'hF;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign if_ack    = state_q == DONE && owner_q == OWN_IF;
   assign d_ack     = state_q == DONE && owner_q == OWN_D;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a
// transaction-level model (grant time, owner, memory image) kept in the bench.
module tb_mem_arbiter;

   localparam int W  = 2;
   localparam int SM = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        if_req = 0, d_req = 0, d_we = 0;
   logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
   logic [3:0]  d_be = 0;
   logic [31:0] if_rdata, d_rdata, ram_wdata, ram_rdata;
   logic        if_ack, d_ack, ram_ce_n, ram_oe_n, ram_we_n, busy;
   logic [19:0] ram_addr;
   logic [3:0]  ram_be_n;

   mem_arbiter #(.WAIT_CYCLES(W), .STARVE_MAX(SM)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_be_n(ram_be_n),
      .busy(busy)
   );

   // Second instance with single-cycle strobes, read-only memory image.
   logic        w1_req = 0;
   logic [31:0] w1_daddr = 0, w1_rdata, w1_ram_rdata;
   logic        w1_ack, w1_busy;
   logic [19:0] w1_ram_addr;
   logic [31:0] w1_unused_ifrdata, w1_unused_wdata;
   logic        w1_unused_ifack, w1_unused_ce, w1_unused_oe, w1_unused_we;
   logic [3:0]  w1_unused_be;
   assign w1_ram_rdata = 32'hC0DE0000 | {12'h0, w1_ram_addr};

   mem_arbiter #(.WAIT_CYCLES(1), .STARVE_MAX(SM)) u_w1 (
      .clk(clk), .rst(rst),
      .if_req(1'b0), .if_addr(32'h0), .if_rdata(w1_unused_ifrdata), .if_ack(w1_unused_ifack),
      .d_req(w1_req), .d_we(1'b0), .d_be(4'hF), .d_addr(w1_daddr), .d_wdata(32'h0),
      .d_rdata(w1_rdata), .d_ack(w1_ack),
      .ram_addr(w1_ram_addr), .ram_wdata(w1_unused_wdata), .ram_rdata(w1_ram_rdata),
      .ram_ce_n(w1_unused_ce), .ram_oe_n(w1_unused_oe), .ram_we_n(w1_unused_we),
      .ram_be_n(w1_unused_be), .busy(w1_busy)
   );

   function automatic logic [31:0] fillv(input int i);
      return 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0F0F;
   endfunction

   // Board SRAM: asynchronous read, byte-masked write while CE and WE are low.
   logic [31:0] sram [0:1023];
   bit          s_filled = 0;
   logic        pl_en = 0;
   logic [9:0]  pl_idx = 0;
   logic [31:0] pl_val = 0;
   assign ram_rdata = sram[ram_addr[9:0]];
   always @(posedge clk) begin
      if (!s_filled) begin
         for (int i = 0; i < 1024; i++) sram[i] <= fillv(i);
         s_filled <= 1;
      end
      if (pl_en) sram[pl_idx] <= pl_val;
      if (!ram_ce_n && !ram_we_n)
         for (int i = 0; i < 4; i++)
            if (!ram_be_n[i]) sram[ram_addr[9:0]][8*i +: 8] <= ram_wdata[8*i +: 8];
   end

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: one access owns the SRAM from grant cycle g for W cycles, acks in cycle g+W,
   // and the port is free to grant again at edge g+W+2. Memory effects applied at completion.
   logic [31:0] mmem [0:1023];
   bit          m_filled = 0, have_g = 0, take_f, m_own, m_we;
   int          cyc = 0, g = 0, starve = 0;
   logic [3:0]  m_be = 0;
   logic [19:0] m_addr = 0;
   logic [31:0] m_wdata = 0, m_if_rdata = 0, m_d_rdata = 0;
   always @(posedge clk or negedge rst) begin
      if (!m_filled) begin
         for (int i = 0; i < 1024; i++) mmem[i] = fillv(i);
         m_filled = 1;
      end
      if (pl_en) mmem[pl_idx] = pl_val;
      if (!rst) begin
         cyc = 0; have_g = 0; starve = 0; m_if_rdata = 0; m_d_rdata = 0;
      end else begin
         cyc++;
         if (have_g && cyc == g + W) begin
            if (m_we) begin
               for (int i = 0; i < 4; i++)
                  if (m_be[i]) mmem[m_addr[9:0]][8*i +: 8] = m_wdata[8*i +: 8];
            end else if (m_own) m_d_rdata = mmem[m_addr[9:0]];
            else m_if_rdata = mmem[m_addr[9:0]];
         end
         if ((!have_g || cyc >= g + W + 2) && (d_req || if_req)) begin
            take_f = !d_req;
`ifdef ARB_STARVE_GUARD_EN
            if (d_req && if_req && starve == SM) take_f = 1;
            if (take_f) starve = 0;
            else if (if_req) starve++;
`endif
            have_g = 1; g = cyc; m_own = !take_f;
            m_addr  = take_f ? if_addr[21:2] : d_addr[21:2];
            m_we    = !take_f && d_we;
            m_be    = m_we ? d_be : 4'hF;
            m_wdata = d_wdata;
         end
      end
   end

   bit acc, dn;
   always @(negedge clk) begin
      if (rst) begin
         acc = have_g && cyc >= g && cyc < g + W;
         dn  = have_g && cyc == g + W;
         chk("busy", busy, acc || dn);
         chk("ce_n", ram_ce_n, !(acc || dn));
         chk("oe_n", ram_oe_n, !(acc && !m_we));
         chk("we_n", ram_we_n, !(acc && m_we));
         chk("if_ack", if_ack, dn && !m_own);
         chk("d_ack", d_ack, dn && m_own);
         chk("if_rdata", if_rdata, m_if_rdata);
         chk("d_rdata", d_rdata, m_d_rdata);
         if (acc) chk("be_n", ram_be_n, 4'(~m_be));
         if (acc || dn) chk("ram_addr", ram_addr, m_addr);
         if ((acc || dn) && m_we) chk("ram_wdata", ram_wdata, m_wdata);
         if (if_ack && d_ack) chk("ack_overlap", 1, 0);
      end
   end

   task automatic preload(input int idx, input logic [31:0] v);
      pl_idx = 10'(idx); pl_val = v; pl_en = 1;
      @(negedge clk);
      pl_en = 0;
   endtask

   task automatic do_reset;
      if_req = 0; d_req = 0; d_we = 0; w1_req = 0;
      @(negedge clk); #2 rst = 0;
      repeat (2) @(negedge clk);
      #2 rst = 1;
      @(negedge clk);
   endtask

   initial begin
      int ack_at, oe_cnt, acks, da, ia, ovl, ic, nacks;
      logic [3:0]  be_seen;
      logic [5:0]  pk;
      logic [4:0]  bz, ak;
      logic [31:0] dat0, dat1, a;
      bit          seq[$];

      do_reset();
      chk("rst_busy", busy, 0);
      chk("rst_ce_n", ram_ce_n, 1);
      chk("rst_be_n", ram_be_n, 4'hF);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_if_rdata", if_rdata, 0);

      // Fetch read
      preload(10'h010, 32'h24020005);
      if_addr = 32'h40; if_req = 1; ack_at = -1; oe_cnt = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (!ram_oe_n) oe_cnt++;
         if (if_ack && ack_at < 0) begin ack_at = i; if_req = 0; end
      end
      chk("fetch_latency", ack_at, 3);
      chk("fetch_oe_cycles", oe_cnt, 2);
      chk("fetch_data", if_rdata, 32'h24020005);

      // Byte store
      preload(10'h080, 32'h11223344);
      d_we = 1; d_be = 4'b0010; d_addr = 32'h200; d_wdata = 32'h0000AB00; d_req = 1;
      acks = 0; be_seen = 4'hF;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (!ram_we_n) be_seen = ram_be_n;
         if (d_ack) begin acks++; d_req = 0; end
      end
      d_we = 0;
      chk("store_be_n", be_seen, 4'b1101);
      chk("store_acks", acks, 1);
      chk("store_word", sram[10'h080], 32'h1122AB44);
      chk("store_keeps_drdata", d_rdata, 0);

      // Contention
      d_addr = 32'h204; if_addr = 32'h44; d_req = 1; if_req = 1;
      da = -1; ia = -1; ovl = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (d_ack && if_ack) ovl++;
         if (d_ack && da < 0) begin da = i; d_req = 0; end
         if (if_ack && ia < 0) begin ia = i; if_req = 0; end
      end
      chk("cont_d_ack", da, 3);
      chk("cont_if_ack", ia, 7);
      chk("cont_overlap", ovl, 0);

      // Starvation
      do_reset();
      if_addr = 32'h48; d_addr = 32'h208; d_we = 0; if_req = 1; d_req = 1; ic = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (d_ack) seq.push_back(1'b1);
         if (if_ack) begin seq.push_back(1'b0); ic++; end
      end
      d_req = 0; if_req = 0;
      chk("starve_ack_count", seq.size() >= 9, 1);
`ifdef ARB_STARVE_GUARD_EN
      pk = 0;
      for (int i = 0; i < 6 && i < seq.size(); i++) pk = {pk[4:0], seq[i]};
      chk("starve_order", pk, 6'b111101);
`else
      chk("starve_if_acks", ic, 0);
`endif
      repeat (6) @(negedge clk);

      // Reset during a store
      do_reset();
      preload(10'h040, 32'hDEADBEEF);
      d_we = 1; d_be = 4'hF; d_addr = 32'h100; d_wdata = 32'h12345678; d_req = 1;
      @(negedge clk);
      chk("pre_rst_we_n", ram_we_n, 0);
      #2 rst = 0;
      #1;
      chk("mid_rst_ce_n", ram_ce_n, 1);
      chk("mid_rst_we_n", ram_we_n, 1);
      chk("mid_rst_oe_n", ram_oe_n, 1);
      chk("mid_rst_be_n", ram_be_n, 4'hF);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_d_ack", d_ack, 0);
      d_req = 0; d_we = 0;
      repeat (2) @(negedge clk);
      #2 rst = 1;
      acks = 0;
      for (int i = 0; i < 6; i++) begin @(negedge clk); if (d_ack) acks++; end
      chk("rst_no_ack", acks, 0);
      chk("rst_word_kept", sram[10'h040], 32'hDEADBEEF);

      // Single-wait-cycle back-to-back loads
      w1_daddr = 32'h0; w1_req = 1; nacks = 0; bz = 0; ak = 0; dat0 = 0; dat1 = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bz = {bz[3:0], w1_busy};
         ak = {ak[3:0], w1_ack};
         if (w1_ack) begin
            if (nacks == 0) begin dat0 = w1_rdata; w1_daddr = 32'h4; end
            else begin dat1 = w1_rdata; w1_req = 0; end
            nacks++;
         end
      end
      chk("w1_busy_pattern", bz, 5'b11011);
      chk("w1_ack_pattern", ak, 5'b01001);
      chk("w1_data0", dat0, 32'hC0DE0000);
      chk("w1_data1", dat1, 32'hC0DE0001);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (d_ack || !d_req) begin
            d_req = $urandom_range(0, 2) == 0;
            a = $urandom(); a[21:12] = 0; a[1:0] = 0;
            d_addr = a; d_we = $urandom_range(0, 1) == 1; d_be = 4'($urandom()); d_wdata = $urandom();
         end else if ($urandom_range(0, 15) == 0) d_req = 0;
         if (if_ack || !if_req) begin
            if_req = $urandom_range(0, 1) == 1;
            a = $urandom(); a[21:12] = 0; a[1:0] = 0;
            if_addr = a;
         end
      end
      d_req = 0; if_req = 0;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 1024; i++) chk("mem_image", sram[i], mmem[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
